// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizes for the pipeline hazard controller.
// Scoreboard width, register count and sequencer state encoding.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam int SB_W  = 2;
    localparam int REG_N = 32;
    localparam int RA_W  = $clog2(REG_N);

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy counters for in-flight rd writes.
// Load on issue, count down each advancing cycle, hold while frozen.
module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int SB_LAT = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_hold,
    input  logic            i_load_en,
    input  logic [RA_W-1:0] i_load_addr,
    input  logic [RA_W-1:0] i_rs1_addr,
    input  logic [RA_W-1:0] i_rs2_addr,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    output logic            o_any_busy
);

    logic [SB_W-1:0] cnt [REG_N];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < REG_N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < REG_N; i++) begin
                if (!i_hold) begin
                    // a fresh load wins over the decrement of the same entry
                    if (i_load_en && (i_load_addr == RA_W'(i))) begin
                        cnt[i] <= SB_W'(SB_LAT);
                    end else if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    assign o_rs1_busy = (i_rs1_addr != '0) && (cnt[i_rs1_addr] != '0);
    assign o_rs2_busy = (i_rs2_addr != '0) && (cnt[i_rs2_addr] != '0);

    always_comb begin
        o_any_busy = 1'b0;
        for (int i = 1; i < REG_N; i++) begin
            o_any_busy = o_any_busy | (cnt[i] != '0);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage non-forwarding pipeline.
// Priority freeze > redirect > raw; MEM wait watchdog.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SB_LAT  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [RA_W-1:0] i_ID_rs1_addr,
    input  logic [RA_W-1:0] i_ID_rs2_addr,
    input  logic            i_ID_rs1_used,
    input  logic            i_ID_rs2_used,
    input  logic [RA_W-1:0] i_ID_rd_addr,
    input  logic            i_ID_rd_wren,
    input  logic            i_EX_pc_sel,
    input  logic            i_MEM_mem_access,
    input  logic            i_mem_ready,
    output logic            o_pc_stall,
    output logic            o_IF_ID_stall,
    output logic            o_ID_EX_stall,
    output logic            o_EX_MEM_stall,
    output logic            o_MEM_WB_stall,
    output logic            o_IF_ID_flush,
    output logic            o_ID_EX_flush,
    output logic            o_EX_MEM_flush,
    output logic            o_MEM_WB_flush,
    output logic            o_mispred,
    output logic            o_sb_busy,
    output logic            o_mem_timeout
);

    logic freeze;
    logic redirect;
    logic raw;
    logic raw_stall;
    logic issue;
    logic load_en;
    logic rs1_busy;
    logic rs2_busy;

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic [7:0]  wait_q;
    logic [7:0]  wait_d;
    logic        timeout_q;
    logic        timeout_d;

    assign freeze    = i_MEM_mem_access & ~i_mem_ready;
    assign raw       = (i_ID_rs1_used & rs1_busy)
                     | (i_ID_rs2_used & rs2_busy);
    assign redirect  = i_EX_pc_sel & ~freeze;
    assign raw_stall = raw & ~freeze & ~i_EX_pc_sel;
    assign issue     = ~freeze & ~i_EX_pc_sel & ~raw;
    assign load_en   = issue & i_ID_rd_wren
                     & (i_ID_rd_addr != '0);

    reg_scoreboard #(
        .SB_LAT (SB_LAT)
    ) u_sb (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_hold      (freeze),
        .i_load_en   (load_en),
        .i_load_addr (i_ID_rd_addr),
        .i_rs1_addr  (i_ID_rs1_addr),
        .i_rs2_addr  (i_ID_rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_any_busy  (o_sb_busy)
    );

    assign o_pc_stall     = freeze | raw_stall;
    assign o_IF_ID_stall  = freeze | raw_stall;
    assign o_ID_EX_stall  = freeze;
    assign o_EX_MEM_stall = freeze;
    assign o_MEM_WB_stall = 1'b0;
    assign o_IF_ID_flush  = redirect;
    assign o_ID_EX_flush  = redirect | raw_stall;
    assign o_EX_MEM_flush = 1'b0;
    assign o_MEM_WB_flush = freeze;
    assign o_mispred      = redirect;
    assign o_mem_timeout  = timeout_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                wait_d = '0;
                if (freeze) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                // saturate so a long stall cannot wrap past the limit
                if (wait_q != 8'(TIMEOUT)) wait_d = wait_q + 8'd1;
                if (i_mem_ready) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (wait_q == 8'(TIMEOUT)) timeout_d = 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Hand-computed stall/flush vectors and scoreboard values.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_u;
    logic       rs2_u;
    logic [4:0] rd;
    logic       rd_we;
    logic       pc_sel;
    logic       mem_acc;
    logic       mem_rdy;

    logic pc_st, ifid_st, idex_st, exmem_st, memwb_st;
    logic ifid_fl, idex_fl, exmem_fl, memwb_fl;
    logic mispred, sb_busy, mem_to;

    int n_cmp;
    int n_bad;

    // {pc,ifid,idex,exmem,memwb stall, ifid,idex,exmem,memwb flush, mispred}
    localparam logic [9:0] V_IDLE  = 10'b00000_00000;
    localparam logic [9:0] V_RAW   = 10'b11000_01000;
    localparam logic [9:0] V_REDIR = 10'b00000_11001;
    localparam logic [9:0] V_FRZ   = 10'b11110_00010;

    logic [9:0] ctl;
    assign ctl = {pc_st, ifid_st, idex_st, exmem_st, memwb_st,
                  ifid_fl, idex_fl, exmem_fl, memwb_fl, mispred};

    pipe_hazard_ctrl u_dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_ID_rs1_addr    (rs1),
        .i_ID_rs2_addr    (rs2),
        .i_ID_rs1_used    (rs1_u),
        .i_ID_rs2_used    (rs2_u),
        .i_ID_rd_addr     (rd),
        .i_ID_rd_wren     (rd_we),
        .i_EX_pc_sel      (pc_sel),
        .i_MEM_mem_access (mem_acc),
        .i_mem_ready      (mem_rdy),
        .o_pc_stall       (pc_st),
        .o_IF_ID_stall    (ifid_st),
        .o_ID_EX_stall    (idex_st),
        .o_EX_MEM_stall   (exmem_st),
        .o_MEM_WB_stall   (memwb_st),
        .o_IF_ID_flush    (ifid_fl),
        .o_ID_EX_flush    (idex_fl),
        .o_EX_MEM_flush   (exmem_fl),
        .o_MEM_WB_flush   (memwb_fl),
        .o_mispred        (mispred),
        .o_sb_busy        (sb_busy),
        .o_mem_timeout    (mem_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; rs1_u = 0; rs2_u = 0;
        rd = '0; rd_we = 0; pc_sel = 0;
        mem_acc = 0; mem_rdy = 0;
    endtask

    // move to the next cycle's input window
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic id_ins(input logic [4:0] a1, input logic u1,
                          input logic [4:0] a2, input logic u2,
                          input logic [4:0] d, input logic we);
        rs1 = a1; rs1_u = u1; rs2 = a2; rs2_u = u2;
        rd = d; rd_we = we;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rst_n = 1'b0;
        repeat (2) nxt();
        rst_n = 1'b1;
        nxt();
        #1;
        chk("rst_ctl", 32'(ctl), 32'(V_IDLE));
        chk("rst_busy", 32'(sb_busy), 32'd0);
        chk("rst_to", 32'(mem_to), 32'd0);
        chk("rst_state", 32'(u_dut.state_q), 32'd0);

        // addi x5 then add x6,x5,x1
        id_ins(5'd0, 1, 5'd0, 0, 5'd5, 1);
        #1 chk("t1_issue", 32'(ctl), 32'(V_IDLE));
        nxt();
        id_ins(5'd5, 1, 5'd1, 1, 5'd6, 1);
        #1 chk("t1_raw0", 32'(ctl), 32'(V_RAW));
        chk("t1_cnt2", 32'(u_dut.u_sb.cnt[5]), 32'd2);
        chk("t1_busy", 32'(sb_busy), 32'd1);
        nxt();
        #1 chk("t1_raw1", 32'(ctl), 32'(V_RAW));
        chk("t1_cnt1", 32'(u_dut.u_sb.cnt[5]), 32'd1);
        nxt();
        #1 chk("t1_go", 32'(ctl), 32'(V_IDLE));
        chk("t1_cnt0", 32'(u_dut.u_sb.cnt[5]), 32'd0);
        nxt();
        idle();
        #1 chk("t1_cnt6", 32'(u_dut.u_sb.cnt[6]), 32'd2);
        repeat (3) nxt();
        #1 chk("t1_drain", 32'(sb_busy), 32'd0);

        // squash of a stalled dependent by a taken branch
        id_ins(5'd0, 0, 5'd0, 0, 5'd7, 1);
        nxt();
        id_ins(5'd7, 1, 5'd0, 0, 5'd8, 1);
        #1 chk("t2_raw", 32'(ctl), 32'(V_RAW));
        nxt();
        pc_sel = 1;
        #1 chk("t2_redir", 32'(ctl), 32'(V_REDIR));
        chk("t2_cnt7", 32'(u_dut.u_sb.cnt[7]), 32'd1);
        nxt();
        idle();
        #1 chk("t2_cnt8", 32'(u_dut.u_sb.cnt[8]), 32'd0);
        chk("t2_busy", 32'(sb_busy), 32'd0);

        // lw waits 4 cycles in MEM; branch in EX must be held off
        id_ins(5'd0, 0, 5'd0, 0, 5'd9, 1);
        nxt();
        id_ins(5'd9, 1, 5'd0, 0, 5'd10, 1);
        mem_acc = 1;
        mem_rdy = 0;
        pc_sel = 1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_frz", 32'(ctl), 32'(V_FRZ));
            chk("t3_cnt9", 32'(u_dut.u_sb.cnt[9]), 32'd2);
            nxt();
            #1 chk("t3_wait", 32'(u_dut.state_q), 32'd1);
        end
        mem_rdy = 1;
        pc_sel = 0;
        #1 chk("t3_rel", 32'(ctl), 32'(V_RAW));
        nxt();
        idle();
        #1 chk("t3_run", 32'(u_dut.state_q), 32'd0);
        chk("t3_cnt9b", 32'(u_dut.u_sb.cnt[9]), 32'd1);
        repeat (3) nxt();

        // x0 writer then x0 reader
        id_ins(5'd0, 1, 5'd0, 1, 5'd0, 1);
        #1 chk("t4_w", 32'(ctl), 32'(V_IDLE));
        nxt();
        id_ins(5'd0, 1, 5'd0, 1, 5'd11, 1);
        #1 chk("t4_r", 32'(ctl), 32'(V_IDLE));
        chk("t4_busy", 32'(sb_busy), 32'd0);
        nxt();
        idle();
        repeat (3) nxt();

        // memory watchdog
        mem_acc = 1;
        mem_rdy = 0;
        for (int k = 0; k < 258; k++) begin
            if (k == 100) begin
                #1 chk("t5_early", 32'(mem_to), 32'd0);
            end
            nxt();
        end
        #1 chk("t5_to", 32'(mem_to), 32'd1);
        mem_rdy = 1;
        nxt();
        idle();
        #1 chk("t5_sticky", 32'(mem_to), 32'd1);
        rst_n = 1'b0;
        #1 chk("t5_clr", 32'(mem_to), 32'd0);
        chk("t5_ctl", 32'(ctl), 32'(V_IDLE));
        nxt();
        rst_n = 1'b1;
        nxt();

        // reset in the middle of a RAW stall
        id_ins(5'd0, 0, 5'd0, 0, 5'd7, 1);
        nxt();
        id_ins(5'd7, 1, 5'd0, 0, 5'd12, 1);
        #1 chk("t6_raw", 32'(ctl), 32'(V_RAW));
        chk("t6_cnt7", 32'(u_dut.u_sb.cnt[7]), 32'd2);
        rst_n = 1'b0;
        #1 chk("t6_busy0", 32'(sb_busy), 32'd0);
        chk("t6_ctl0", 32'(ctl), 32'(V_IDLE));
        nxt();
        rst_n = 1'b1;
        idle();
        nxt();
        #1 chk("t6_busy1", 32'(sb_busy), 32'd0);
        chk("t6_ctl1", 32'(ctl), 32'(V_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
